// File: rtl/yuv444_to_yuv422.sv
// yuv444_to_yuv422
//   Chroma subsampler: converts a full-rate 4:4:4 Y/U/V pixel stream into 4:2:2.
//   Luma passes through unchanged. Chroma is averaged over co-sited even/odd pixel
//   pairs and sent as one interleaved sample per pixel. Every output has a fixed
//   latency of two clocks, so the sync signals stay aligned with the video.
//
// Parameters
//   C_BPC       bits per component on Y/U/V/C
//   C_CR_FIRST  0: Cb on even pixels, Cr on odd; 1: swapped
//
// Ports
//   CLK_I            pixel clock
//   RSTN_I           asynchronous active-low reset
//   DE_I/HS_I/VS_I   input timing
//   Y_I/U_I/V_I      4:4:4 pixel components
//   DE_O/HS_O/VS_O   timing delayed by two clocks
//   Y_O              luma delayed by two clocks (0 when DE_O=0)
//   C_O              interleaved chroma (neutral value when DE_O=0)
//   PH_O             pixel phase within its pair: 0 = even, 1 = odd

module yuv444_to_yuv422 #(
   parameter int unsigned C_BPC      = 8,
   parameter bit          C_CR_FIRST = 1'b0
) (
   input  logic             CLK_I,
   input  logic             RSTN_I,
   input  logic             DE_I,
   input  logic             HS_I,
   input  logic             VS_I,
   input  logic [C_BPC-1:0] Y_I,
   input  logic [C_BPC-1:0] U_I,
   input  logic [C_BPC-1:0] V_I,
   output logic             DE_O,
   output logic             HS_O,
   output logic             VS_O,
   output logic [C_BPC-1:0] Y_O,
   output logic [C_BPC-1:0] C_O,
   output logic             PH_O
);

   localparam logic [C_BPC-1:0] Neutral = {1'b1, {(C_BPC-1){1'b0}}};

   // Phase of the next DE pixel; cleared by any DE gap so each run starts even.
   logic             phase_q;
   logic             ph_in;

   // Stage 1
   logic             de1_q, hs1_q, vs1_q, ph1_q;
   logic [C_BPC-1:0] y1_q, u1_q, v1_q;

   // Stage 2 (outputs)
   logic             de2_q, hs2_q, vs2_q, ph2_q;
   logic [C_BPC-1:0] y2_q;
   logic [C_BPC-1:0] avg_u_q, avg_v_q;

   logic             pair_load;
   logic [C_BPC-1:0] avg_u_d, avg_v_d;

   assign ph_in     = DE_I & phase_q;
   // S1 holds an even active pixel: its pair chroma is resolved this cycle.
   assign pair_load = de1_q & ~ph1_q;

   always_comb begin
      avg_u_d = u1_q;
      avg_v_d = v1_q;
      // With an even pixel in S1, an active input is necessarily its odd partner;
      // an inactive input means the even pixel is an orphan and keeps its own chroma.
      if (DE_I) begin
         avg_u_d = C_BPC'(({1'b0, u1_q} + {1'b0, U_I} + (C_BPC+1)'(1)) >> 1);
         avg_v_d = C_BPC'(({1'b0, v1_q} + {1'b0, V_I} + (C_BPC+1)'(1)) >> 1);
      end
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         phase_q <= 1'b0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         ph1_q   <= 1'b0;
         y1_q    <= '0;
         u1_q    <= '0;
         v1_q    <= '0;
         de2_q   <= 1'b0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
         ph2_q   <= 1'b0;
         y2_q    <= '0;
         avg_u_q <= Neutral;
         avg_v_q <= Neutral;
      end else begin
         phase_q <= DE_I & ~phase_q;
         de1_q   <= DE_I;
         hs1_q   <= HS_I;
         vs1_q   <= VS_I;
         ph1_q   <= ph_in;
         y1_q    <= Y_I;
         u1_q    <= U_I;
         v1_q    <= V_I;
         de2_q   <= de1_q;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         ph2_q   <= ph1_q;
         y2_q    <= y1_q;
         // Averages load with the even pixel and are held through its odd partner.
         if (pair_load) begin
            avg_u_q <= avg_u_d;
            avg_v_q <= avg_v_d;
         end
      end
   end

   always_comb begin
      DE_O = de2_q;
      HS_O = hs2_q;
      VS_O = vs2_q;
      Y_O  = '0;
      C_O  = Neutral;
      PH_O = 1'b0;
      if (de2_q) begin
         Y_O  = y2_q;
         PH_O = ph2_q;
         C_O  = (ph2_q ^ C_CR_FIRST) ? avg_v_q : avg_u_q;
      end
   end

endmodule

// File: tb/tb_yuv444_to_yuv422.sv
// tb_yuv444_to_yuv422
//   Drives a prebuilt stimulus table (directed lines followed by random DE runs)
//   into two instances (Cb-first and Cr-first) and compares every output two
//   clocks later against a line-level reference model. Ends with a mid-line
//   asynchronous reset and a short line after release.

module tb_yuv444_to_yuv422;

   localparam int N = 320;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       de, hs, vs;
   logic [7:0] y, u, v;

   logic       de_a, hs_a, vs_a, ph_a;
   logic [7:0] y_a, c_a;
   logic       de_b, hs_b, vs_b, ph_b;
   logic [7:0] y_b, c_b;

   always #5 clk = ~clk;

   yuv444_to_yuv422 #(.C_BPC(8), .C_CR_FIRST(1'b0)) u_dut_cb (
      .CLK_I(clk), .RSTN_I(rst_n), .DE_I(de), .HS_I(hs), .VS_I(vs),
      .Y_I(y), .U_I(u), .V_I(v),
      .DE_O(de_a), .HS_O(hs_a), .VS_O(vs_a), .Y_O(y_a), .C_O(c_a), .PH_O(ph_a)
   );

   yuv444_to_yuv422 #(.C_BPC(8), .C_CR_FIRST(1'b1)) u_dut_cr (
      .CLK_I(clk), .RSTN_I(rst_n), .DE_I(de), .HS_I(hs), .VS_I(vs),
      .Y_I(y), .U_I(u), .V_I(v),
      .DE_O(de_b), .HS_O(hs_b), .VS_O(vs_b), .Y_O(y_b), .C_O(c_b), .PH_O(ph_b)
   );

   bit s_de[N], s_hs[N], s_vs[N];
   int s_y[N], s_u[N], s_v[N];
   int pos[N];
   int dir_cb[N], dir_cr[N];
   int len = 0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input bit d, input bit h, input bit vv, input int yy, input int uu,
                       input int vc);
      s_de[len] = d;
      s_hs[len] = h;
      s_vs[len] = vv;
      s_y[len]  = yy;
      s_u[len]  = uu;
      s_v[len]  = vc;
      len++;
   endtask

   // Expected chroma for the pixel entered at cycle n: pair it with its neighbour
   // in the DE run (odd pixels pair backwards, even pixels forwards if present).
   function automatic int exp_c(input int n, input bit cr_first);
      int  p;
      bit  has;
      int  au, av;
      bit  odd;
      if (!s_de[n]) return 128;
      odd = (pos[n] % 2) == 1;
      if (odd) begin
         p = n - 1; has = 1'b1;
      end else begin
         p = n + 1; has = (n + 1 < N) && s_de[n+1];
      end
      au = has ? (s_u[n] + s_u[p] + 1) / 2 : s_u[n];
      av = has ? (s_v[n] + s_v[p] + 1) / 2 : s_v[n];
      return (odd ^ cr_first) ? av : au;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_de"}, de_a, 0);
      chk({tag, "_hs"}, hs_a, 0);
      chk({tag, "_vs"}, vs_a, 0);
      chk({tag, "_y"}, y_a, 0);
      chk({tag, "_ph"}, ph_a, 0);
      chk({tag, "_c"}, c_a, 128);
      chk({tag, "_c_cr"}, c_b, 128);
   endtask

   initial begin
      int m;
      for (int i = 0; i < N; i++) begin
         dir_cb[i] = -1;
         dir_cr[i] = -1;
      end

      // Directed part of the table
      push(0, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 0);
      dir_cb[len] = 15;  dir_cr[len] = 105; push(1, 0, 0, 11, 10, 100);
      dir_cb[len] = 105; dir_cr[len] = 15;  push(1, 0, 0, 12, 20, 110);
      dir_cb[len] = 35;  dir_cr[len] = 125; push(1, 0, 0, 13, 30, 120);
      dir_cb[len] = 125; dir_cr[len] = 35;  push(1, 0, 0, 14, 40, 130);
      dir_cb[len] = 128; push(0, 1, 0, 0, 0, 0);
      dir_cb[len] = 55;  push(1, 0, 0, 21, 50, 80);
      dir_cb[len] = 85;  push(1, 0, 0, 22, 60, 90);
      dir_cb[len] = 70;  push(1, 0, 0, 23, 70, 200);
      dir_cb[len] = 128; push(0, 0, 1, 0, 0, 0);
      dir_cb[len] = 255; push(1, 0, 0, 31, 255, 0);
      dir_cb[len] = 1;   push(1, 0, 0, 32, 254, 1);
      push(0, 0, 0, 0, 0, 0);
      dir_cb[len] = 3;   push(1, 0, 0, 41, 2, 6);
      dir_cb[len] = 7;   push(1, 0, 0, 42, 4, 8);
      dir_cb[len] = 128; push(0, 1, 1, 0, 0, 0);
      dir_cb[len] = 9;   push(1, 0, 0, 43, 9, 3);
      dir_cb[len] = 3;   push(1, 0, 0, 44, 9, 3);
      push(0, 0, 0, 0, 0, 0);

      // Random runs and gaps, trailing idle cycles
      while (len < N - 4)
         push($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      while (len < N) push(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < N; i++)
         pos[i] = s_de[i] ? ((i > 0 && s_de[i-1]) ? pos[i-1] + 1 : 0) : 0;

      // Reset state
      rst_n = 1'b0;
      de = 0; hs = 0; vs = 0; y = 0; u = 0; v = 0;
      #1;
      check_reset_outputs("rst0");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Main stream
      for (int n = 0; n < N + 2; n++) begin
         @(posedge clk);
         #1;
         if (n < N) begin
            de = s_de[n]; hs = s_hs[n]; vs = s_vs[n];
            y = 8'(s_y[n]); u = 8'(s_u[n]); v = 8'(s_v[n]);
         end else begin
            de = 0; hs = 0; vs = 0; y = 0; u = 0; v = 0;
         end
         @(negedge clk);
         if (n >= 2) begin
            m = n - 2;
            chk("de", de_a, s_de[m]);
            chk("hs", hs_a, s_hs[m]);
            chk("vs", vs_a, s_vs[m]);
            chk("y", y_a, s_de[m] ? s_y[m] : 0);
            chk("ph", ph_a, s_de[m] ? pos[m] % 2 : 0);
            chk("c", c_a, exp_c(m, 1'b0));
            chk("ph_cr", ph_b, s_de[m] ? pos[m] % 2 : 0);
            chk("c_cr", c_b, exp_c(m, 1'b1));
            if (dir_cb[m] >= 0) chk("c_dir", c_a, dir_cb[m]);
            if (dir_cr[m] >= 0) chk("c_cr_dir", c_b, dir_cr[m]);
         end
      end

      // Reset asserted during the 3rd pixel of a 6-pixel line
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         de = 1; hs = 1; vs = 1; y = 8'(60 + k); u = 8'(k * 7); v = 8'(k * 9);
      end
      #3;
      chk("pre_rst_de", de_a, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      de = 0; hs = 0; vs = 0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Short line after release
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         de = (k < 2); hs = 0; vs = 0;
         y = (k == 0) ? 8'd1 : (k == 1) ? 8'd2 : 8'd0;
         u = (k == 0) ? 8'd20 : (k == 1) ? 8'd31 : 8'd0;
         v = (k == 0) ? 8'd7 : (k == 1) ? 8'd8 : 8'd0;
         @(negedge clk);
         if (k == 2) begin
            chk("post_de0", de_a, 1);
            chk("post_ph0", ph_a, 0);
            chk("post_y0", y_a, 1);
            chk("post_c0", c_a, 26);
            chk("post_c0_cr", c_b, 8);
         end else if (k == 3) begin
            chk("post_de1", de_a, 1);
            chk("post_ph1", ph_a, 1);
            chk("post_y1", y_a, 2);
            chk("post_c1", c_a, 8);
            chk("post_c1_cr", c_b, 26);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
